ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, RAM address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 The module SHALL have parameter STARVE_MAX, default 8, maximum cycles a host request waits before it gains priority.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed next.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-005 The CPU requester port SHALL be:
- cpu_req  in  1  access request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  DATA_W  read data.
REQ-006 The host (loader/debug) requester port SHALL have the same signals prefixed host_, plus host_lock  in  1  burst-lock request.
REQ-007 The RAM side SHALL be:
- ram_read_enable  out  1  read strobe.
- ram_write_enable  out  1  write strobe.
- ram_addr  out  ADDR_W  address.
- ram_wdata  out  DATA_W  write data.
- ram_rdata  in  DATA_W  read data, valid one cycle after ram_read_enable.

Function
REQ-008 Grants SHALL be combinational from current requests and registered state; at most one of cpu_gnt/host_gnt is high per cycle; gnt is never high without the matching req.
REQ-009 A transfer is accepted when req&&gnt in cycle N; RAM command outputs SHALL be registered and driven in cycle N+1 for exactly one cycle.
REQ-010 Read data SHALL return to the issuing requester only: rvalid high, rdata=ram_rdata in cycle N+2; the other port's rvalid stays 0.
REQ-011 Writes SHALL produce no rvalid; acceptance (gnt) is completion from the requester's view.
REQ-012 Throughput SHALL be one accepted transfer per cycle, back-to-back, with no bubble when switching requesters.
REQ-013 Requesters SHALL hold req/we/addr/wdata stable until gnt; the arbiter samples them only in the grant cycle.
REQ-014 FSM states SHALL be IDLE, LAST_CPU, LAST_HOST, HOST_LOCKED; the next state is set by the winner of the cycle (no grant means IDLE).
REQ-015 Default priority SHALL be the CPU; the host wins if cpu_req=0, or wait_cnt==STARVE_MAX, or state==HOST_LOCKED (when the lock feature is enabled).
REQ-016 wait_cnt SHALL increment each cycle host_req&&!host_gnt, saturate at STARVE_MAX, and clear on a host grant.
REQ-017 When the host wins by starvation it SHALL get exactly one grant, after which CPU priority resumes.
REQ-018 Simultaneous cpu_req and host_req with wait_cnt<STARVE_MAX and no lock SHALL grant the CPU.
REQ-019 When neither port requests, ram_read_enable and ram_write_enable SHALL be 0 in the following cycle; ram_addr and ram_wdata hold their last values.

Reset
REQ-020 On reset the FSM SHALL go to IDLE, wait_cnt=0, and all gnt, rvalid and RAM strobes =0; rdata outputs =0.
REQ-021 A reset asserted with a read in flight SHALL drop it, with no rvalid on either port after reset.
REQ-022 No grant SHALL be issued in a cycle where reset is high.

Configuration
REQ-023 Macro RAM_ARB_HOST_LOCK_EN defined: host_gnt while host_lock=1 enters HOST_LOCKED; the host then has absolute priority, the CPU is starved without bound, and the lock exits to LAST_HOST when host_lock=0 is sampled.
REQ-024 RAM_ARB_HOST_LOCK_EN undefined: host_lock is ignored and HOST_LOCKED is unreachable.

Structure
REQ-025 A shared package ram_arb_pkg SHALL hold the FSM state enum, the requester-ID constants (REQ_CPU=0, REQ_HOST=1) and the STARVE_MAX default.
REQ-026 The saturating wait counter SHALL be sub-module arb_wait_counter; the FSM, grant logic and read-tag pipeline stay in ram_arbiter.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- CPU read 0x40 alone, RAM returns 0xDEADBEEF -> cpu_gnt at N, ram_read_enable at N+1, cpu_rvalid with 0xDEADBEEF at N+2, host_rvalid=0.
- cpu_req and host_req both held continuously, STARVE_MAX=8 -> CPU granted 8 cycles, host granted on cycle 9, CPU on cycle 10.
- Alternating CPU write 0x10=0x11 and host read 0x10 back-to-back -> one RAM strobe every cycle, host_rvalid returns 0x11.
- Lock enabled, host_lock=1 with 4 host writes while cpu_req=1 -> 4 consecutive host_gnt, cpu_gnt=0 until host_lock drops.
- Reset pulsed at N+1 of a CPU read -> no cpu_rvalid, all outputs 0, FSM IDLE.
- Lock disabled, host_lock=1 -> behaviour identical to host_lock=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared types and constants for the two-port RAM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LAST_CPU    = 2'd1,
    ST_LAST_HOST   = 2'd2,
    ST_HOST_LOCKED = 2'd3
  } arb_state_e;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int STARVE_MAX_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/arb_wait_counter.sv
// ============================================================================
// arb_wait_counter : saturating count of cycles the host has waited for a grant
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_wait_counter
  import ram_arb_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat_o = (cnt_q == CW'(MAX));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : CPU/host single-port RAM arbiter, CPU priority with host
// starvation escape. Optional host burst lock: RAM_ARB_HOST_LOCK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,

  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic              ram_rd_en_q, ram_wr_en_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              rd_tag_q;
  logic              cpu_rvalid_q, host_rvalid_q;

  logic              starved;
  logic              locked;
  logic              host_pri;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CW-1:0]     wait_cnt;

  arb_wait_counter #(
    .MAX (STARVE_MAX),
    .CW  (CW)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc_i (host_req && !host_gnt),
    .clr_i (host_gnt),
    .cnt_o (wait_cnt),
    .sat_o (starved)
  );

`ifdef RAM_ARB_HOST_LOCK_EN
  assign locked = (state_q == ST_HOST_LOCKED);
`else
  logic unused_host_lock;
  assign locked           = 1'b0;
  assign unused_host_lock = host_lock;
`endif

  always_comb begin
    host_pri = !cpu_req || starved || locked;
    host_gnt = !reset && host_req && host_pri;
    // A locked host keeps the CPU out even on cycles it does not request.
    cpu_gnt  = !reset && cpu_req && !host_gnt && !locked;

    state_d = ST_IDLE;
    if (locked) begin
      state_d = host_lock ? ST_HOST_LOCKED : ST_LAST_HOST;
    end else if (host_gnt) begin
`ifdef RAM_ARB_HOST_LOCK_EN
      state_d = host_lock ? ST_HOST_LOCKED : ST_LAST_HOST;
`else
      state_d = ST_LAST_HOST;
`endif
    end else if (cpu_gnt) begin
      state_d = ST_LAST_CPU;
    end
  end

  assign accept    = cpu_gnt || host_gnt;
  assign sel_we    = host_gnt ? host_we    : cpu_we;
  assign sel_addr  = host_gnt ? host_addr  : cpu_addr;
  assign sel_wdata = host_gnt ? host_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ram_rd_en_q   <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      rd_tag_q      <= REQ_CPU;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_rd_en_q <= accept && !sel_we;
      ram_wr_en_q <= accept && sel_we;
      if (accept) begin
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
        rd_tag_q    <= host_gnt ? REQ_HOST : REQ_CPU;
      end
      // RAM data lands one cycle after the strobe; the tag steers it home.
      cpu_rvalid_q  <= ram_rd_en_q && (rd_tag_q == REQ_CPU);
      host_rvalid_q <= ram_rd_en_q && (rd_tag_q == REQ_HOST);
    end
  end

  assign ram_read_enable  = ram_rd_en_q;
  assign ram_write_enable = ram_wr_en_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = cpu_rvalid_q  ? ram_rdata : '0;
  assign host_rdata  = host_rvalid_q ? ram_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : directed bench for ram_arbiter; the lock scenario follows
// RAM_ARB_HOST_LOCK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        ram_read_enable, ram_write_enable;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_gnt          (cpu_gnt),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rdata        (cpu_rdata),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_lock        (host_lock),
    .host_gnt         (host_gnt),
    .host_rvalid      (host_rvalid),
    .host_rdata       (host_rdata),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  // RAM model: one-cycle read latency, location 0x40 hard-wired to 0xDEADBEEF.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_read_enable)
      ram_rdata <= (ram_addr == 32'h40) ? 32'hDEADBEEF : mem[ram_addr[7:0]];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkst(input string tag, input arb_state_e obs, input arb_state_e exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_lock = 1'b0;
    nxt();

    // Reset state, requests present but reset high
    settle();
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_host_gnt", host_gnt, 1'b0);
    chk1("rst_rd_en", ram_read_enable, 1'b0);
    chk1("rst_wr_en", ram_write_enable, 1'b0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rst_host_rvalid", host_rvalid, 1'b0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk32("rst_host_rdata", host_rdata, 32'h0);
    chkst("rst_state", dut.state_q, ST_IDLE);
    nxt();

    // CPU read of 0x40 alone
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; host_req = 1'b0;
    settle();
    chk1("rd_N_cpu_gnt", cpu_gnt, 1'b1);
    chk1("rd_N_host_gnt", host_gnt, 1'b0);
    nxt();
    cpu_req = 1'b0;
    settle();
    chk1("rd_N1_rd_en", ram_read_enable, 1'b1);
    chk1("rd_N1_wr_en", ram_write_enable, 1'b0);
    chk32("rd_N1_addr", ram_addr, 32'h40);
    chk1("rd_N1_cpu_rvalid", cpu_rvalid, 1'b0);
    nxt();
    settle();
    chk1("rd_N2_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("rd_N2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk1("rd_N2_host_rvalid", host_rvalid, 1'b0);
    chk1("rd_N2_rd_en_idle", ram_read_enable, 1'b0);
    chk32("rd_N2_addr_hold", ram_addr, 32'h40);
    chkst("rd_N2_state", dut.state_q, ST_IDLE);
    nxt();

    // Both requesting continuously: host escapes starvation on cycles 9 and 18
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hA5;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h84; host_wdata = 32'h5A;
    for (int i = 1; i <= 19; i++) begin
      settle();
      chk1($sformatf("starve_cpu_gnt_c%0d", i), cpu_gnt, (i != 9 && i != 18));
      chk1($sformatf("starve_host_gnt_c%0d", i), host_gnt, (i == 9 || i == 18));
      if (i == 10) begin
        chk1("starve_c10_wr_en", ram_write_enable, 1'b1);
        chk32("starve_c10_addr", ram_addr, 32'h84);
        chk32("starve_c10_wdata", ram_wdata, 32'h5A);
      end
      if (i == 11) chk32("starve_c11_addr", ram_addr, 32'h80);
      nxt();
    end
    cpu_req = 1'b0; host_req = 1'b0;
    settle();
    chk1("drop_cpu_gnt", cpu_gnt, 1'b0);
    chk1("drop_host_gnt", host_gnt, 1'b0);
    nxt();

    // Alternating CPU write / host read of 0x10, back to back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h11;
    settle();
    chk1("alt_A_cpu_gnt", cpu_gnt, 1'b1);
    nxt();
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
    settle();
    chk1("alt_B_host_gnt", host_gnt, 1'b1);
    chk1("alt_B_wr_en", ram_write_enable, 1'b1);
    chk32("alt_B_wdata", ram_wdata, 32'h11);
    nxt();
    host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 32'h22;
    settle();
    chk1("alt_C_cpu_gnt", cpu_gnt, 1'b1);
    chk1("alt_C_rd_en", ram_read_enable, 1'b1);
    chk32("alt_C_addr", ram_addr, 32'h10);
    nxt();
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0;
    settle();
    chk1("alt_D_host_gnt", host_gnt, 1'b1);
    chk1("alt_D_host_rvalid", host_rvalid, 1'b1);
    chk32("alt_D_host_rdata", host_rdata, 32'h11);
    chk1("alt_D_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("alt_D_wr_en", ram_write_enable, 1'b1);
    nxt();
    host_req = 1'b0;
    settle();
    chk1("alt_E_rd_en", ram_read_enable, 1'b1);
    nxt();
    settle();
    chk1("alt_F_host_rvalid", host_rvalid, 1'b1);
    chk32("alt_F_host_rdata", host_rdata, 32'h22);
    chk1("alt_F_rd_en", ram_read_enable, 1'b0);
    chk1("alt_F_wr_en", ram_write_enable, 1'b0);
    nxt();

`ifdef RAM_ARB_HOST_LOCK_EN
    // Host burst lock: four host writes while the CPU is shut out
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
    host_addr = 32'h20; host_wdata = 32'h1;
    settle();
    chk1("lock_w1_host_gnt", host_gnt, 1'b1);
    nxt();
    for (int k = 2; k <= 4; k++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      host_addr = 32'h20 + 32'(k); host_wdata = 32'(k);
      settle();
      chk1($sformatf("lock_w%0d_host_gnt", k), host_gnt, 1'b1);
      chk1($sformatf("lock_w%0d_cpu_gnt", k), cpu_gnt, 1'b0);
      chkst($sformatf("lock_w%0d_state", k), dut.state_q, ST_HOST_LOCKED);
      nxt();
    end
    host_req = 1'b0;
    settle();
    chk1("lock_idle_cpu_gnt", cpu_gnt, 1'b0);
    nxt();
    host_lock = 1'b0;
    settle();
    chk1("lock_release_cpu_gnt", cpu_gnt, 1'b0);
    nxt();
    settle();
    chk1("lock_after_cpu_gnt", cpu_gnt, 1'b1);
    chkst("lock_after_state", dut.state_q, ST_LAST_HOST);
    nxt();
`else
    // host_lock ignored: the CPU keeps priority after a host grant
    cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
    host_addr = 32'h20; host_wdata = 32'h1;
    settle();
    chk1("nolock_d1_host_gnt", host_gnt, 1'b1);
    nxt();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'h3;
    settle();
    chk1("nolock_d2_cpu_gnt", cpu_gnt, 1'b1);
    chk1("nolock_d2_host_gnt", host_gnt, 1'b0);
    chkst("nolock_d2_state", dut.state_q, ST_LAST_HOST);
    nxt();
    settle();
    chk1("nolock_d3_cpu_gnt", cpu_gnt, 1'b1);
    chk1("nolock_d3_host_gnt", host_gnt, 1'b0);
    chkst("nolock_d3_state", dut.state_q, ST_LAST_CPU);
    nxt();
`endif
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    settle();
    nxt();

    // Reset pulsed while a CPU read is in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    settle();
    chk1("rstrd_N_cpu_gnt", cpu_gnt, 1'b1);
    nxt();
    cpu_req = 1'b0; reset = 1'b1;
    settle();
    chk1("rstrd_N1_rd_en", ram_read_enable, 1'b1);
    chk1("rstrd_N1_cpu_gnt", cpu_gnt, 1'b0);
    nxt();
    reset = 1'b0;
    settle();
    chk1("rstrd_N2_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rstrd_N2_host_rvalid", host_rvalid, 1'b0);
    chk1("rstrd_N2_rd_en", ram_read_enable, 1'b0);
    chk1("rstrd_N2_wr_en", ram_write_enable, 1'b0);
    chk32("rstrd_N2_addr", ram_addr, 32'h0);
    chk32("rstrd_N2_wdata", ram_wdata, 32'h0);
    chk32("rstrd_N2_cpu_rdata", cpu_rdata, 32'h0);
    chkst("rstrd_N2_state", dut.state_q, ST_IDLE);
    nxt();
    settle();
    chk1("rstrd_N3_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("rstrd_N3_host_rvalid", host_rvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
